fifo_read_scheduler: RTL and testbench

- Sequences read access to an 8-channel SyncFIFO bank. Each cycle it picks one non-empty channel using per-channel configurable priorities with anti-starvation aging.
- Holds the grant for a bounded burst of transfers, then releases it.
- Sits between the per-channel FIFO empty flags and the shared read datapath. It drives the one-hot read-select that steers the shared output mux.

---
 rtl/fifo_read_scheduler_if.sv | 23 ++
 rtl/fifo_read_scheduler.sv | 135 +++++++++++++
 tb/tb_fifo_read_scheduler.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/fifo_read_scheduler_if.sv
// Request, configuration and grant signals between the FIFO bank and the read scheduler.
// The slave modport is the scheduler; the master modport is the FIFO bank / datapath side.
interface fifo_read_scheduler_if;
    logic [7:0] req;
    logic       cfg_we;
    logic [2:0] cfg_ch;
    logic [7:0] cfg_pri;
    logic       gnt_ack;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       busy;

    modport master (
        output req, cfg_we, cfg_ch, cfg_pri, gnt_ack,
        input  gnt, gnt_idx, gnt_valid, busy
    );

    modport slave (
        input  req, cfg_we, cfg_ch, cfg_pri, gnt_ack,
        output gnt, gnt_idx, gnt_valid, busy
    );
endinterface

// File: rtl/fifo_read_scheduler.sv
// Read scheduler for an 8-channel FIFO bank: priority arbitration with aging, burst-bounded grants.
// state | meaning
// IDLE  | no grant; arbitrate among requesting channels each cycle
// BUSY  | grant held until the burst counter expires or the granted FIFO empties
module fifo_read_scheduler #(
    parameter int unsigned BURST_LEN = 4,
    parameter int unsigned AGE_MAX   = 15
) (
    input logic                  clk,
    input logic                  rst_n,
    fifo_read_scheduler_if.slave bus
);
    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [7:0] BURST_INIT = 8'(BURST_LEN);
    localparam logic [7:0] AGE_LIM    = 8'(AGE_MAX);

    state_t     state_q, state_d;
    logic [7:0] pri_q [8];
    logic [7:0] age_q [8];
    logic [7:0] age_d [8];
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] gnt_q, gnt_d;
    logic [2:0] idx_q, idx_d;
    logic       valid_q, valid_d;

    logic [8:0] eff    [8];
    logic [8:0] l1_val [4];
    logic [2:0] l1_idx [4];
    logic [8:0] l2_val [2];
    logic [2:0] l2_idx [2];
    logic [2:0] win_idx;

    // Requesters always outrank idle channels; a starved channel jumps to the top value.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            if (!bus.req[i])
                eff[i] = 9'h000;
            else if (age_q[i] >= AGE_LIM)
                eff[i] = 9'h1FF;
            else
                eff[i] = {1'b1, pri_q[i]};
        end
    end

    always_comb begin
        for (int j = 0; j < 4; j++) begin
            if (eff[2*j] >= eff[2*j+1]) begin
                l1_val[j] = eff[2*j];
                l1_idx[j] = 3'(2*j);
            end else begin
                l1_val[j] = eff[2*j+1];
                l1_idx[j] = 3'(2*j+1);
            end
        end
        for (int k = 0; k < 2; k++) begin
            if (l1_val[2*k] >= l1_val[2*k+1]) begin
                l2_val[k] = l1_val[2*k];
                l2_idx[k] = l1_idx[2*k];
            end else begin
                l2_val[k] = l1_val[2*k+1];
                l2_idx[k] = l1_idx[2*k+1];
            end
        end
        win_idx = (l2_val[0] >= l2_val[1]) ? l2_idx[0] : l2_idx[1];
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        age_d   = age_q;
        case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    state_d = BUSY;
                    gnt_d   = 8'b1 << win_idx;
                    idx_d   = win_idx;
                    valid_d = 1'b1;
                    cnt_d   = BURST_INIT;
                    for (int i = 0; i < 8; i++) begin
                        if (3'(i) == win_idx)
                            age_d[i] = 8'd0;
                        else if (bus.req[i] && age_q[i] != 8'hFF)
                            age_d[i] = age_q[i] + 8'd1;
                    end
                end
            end
            BUSY: begin
                // An emptied FIFO or the last ack of the burst ends the grant.
                if (!bus.req[idx_q] || (bus.gnt_ack && cnt_q == 8'd1)) begin
                    state_d = IDLE;
                    gnt_d   = 8'd0;
                    valid_d = 1'b0;
                end else if (bus.gnt_ack) begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= 8'd0;
            idx_q   <= 3'd0;
            valid_q <= 1'b0;
            cnt_q   <= 8'd0;
            for (int i = 0; i < 8; i++) age_q[i] <= 8'd0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            age_q   <= age_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) pri_q[i] <= 8'd0;
        end else if (bus.cfg_we) begin
            pri_q[bus.cfg_ch] <= bus.cfg_pri;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_idx   = idx_q;
    assign bus.gnt_valid = valid_q;
    assign bus.busy      = (state_q == BUSY);
endmodule

// File: tb/tb_fifo_read_scheduler.sv
// Directed bench: instance a uses default parameters, instance b uses BURST_LEN=1, AGE_MAX=3.
module tb_fifo_read_scheduler;
    logic clk;
    logic rst_n;
    int   n_cmp  = 0;
    int   n_fail = 0;

    fifo_read_scheduler_if ifa ();
    fifo_read_scheduler_if ifb ();

    fifo_read_scheduler #(.BURST_LEN(4), .AGE_MAX(15)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa.slave)
    );

    fifo_read_scheduler #(.BURST_LEN(1), .AGE_MAX(3)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic chk_a(input string tag, input logic [7:0] g, input logic [2:0] i, input logic v);
        check({tag, ".gnt"},       {1'b0, ifa.gnt},        {1'b0, g});
        check({tag, ".gnt_idx"},   {6'd0, ifa.gnt_idx},    {6'd0, i});
        check({tag, ".gnt_valid"}, {8'd0, ifa.gnt_valid},  {8'd0, v});
        check({tag, ".busy"},      {8'd0, ifa.busy},       {8'd0, v});
    endtask

    task automatic chk_b(input string tag, input logic [7:0] g, input logic [2:0] i, input logic v);
        check({tag, ".gnt"},       {1'b0, ifb.gnt},        {1'b0, g});
        check({tag, ".gnt_idx"},   {6'd0, ifb.gnt_idx},    {6'd0, i});
        check({tag, ".gnt_valid"}, {8'd0, ifb.gnt_valid},  {8'd0, v});
        check({tag, ".busy"},      {8'd0, ifb.busy},       {8'd0, v});
    endtask

    task automatic cfg_a(input logic [2:0] ch, input logic [7:0] pri);
        ifa.cfg_we  = 1'b1;
        ifa.cfg_ch  = ch;
        ifa.cfg_pri = pri;
        tick();
        ifa.cfg_we  = 1'b0;
    endtask

    task automatic cfg_b(input logic [2:0] ch, input logic [7:0] pri);
        ifb.cfg_we  = 1'b1;
        ifb.cfg_ch  = ch;
        ifb.cfg_pri = pri;
        tick();
        ifb.cfg_we  = 1'b0;
    endtask

    logic [2:0] age_seq [6];
    logic [7:0] oh;

    initial begin
        rst_n       = 1'b0;
        ifa.req     = 8'd0;
        ifa.cfg_we  = 1'b0;
        ifa.cfg_ch  = 3'd0;
        ifa.cfg_pri = 8'd0;
        ifa.gnt_ack = 1'b0;
        ifb.req     = 8'd0;
        ifb.cfg_we  = 1'b0;
        ifb.cfg_ch  = 3'd0;
        ifb.cfg_pri = 8'd0;
        ifb.gnt_ack = 1'b0;
        age_seq     = '{3'd7, 3'd7, 3'd7, 3'd0, 3'd7, 3'd7};

        #12;
        chk_a("reset_a", 8'd0, 3'd0, 1'b0);
        chk_b("reset_b", 8'd0, 3'd0, 1'b0);
        rst_n = 1'b1;

        // priority win
        cfg_a(3'd2, 8'h10);
        cfg_a(3'd5, 8'h40);
        ifa.req = 8'b0010_0100;
        tick();
        chk_a("pri_win", 8'b0010_0000, 3'd5, 1'b1);

        // burst of four acks, then one idle bubble and a regrant
        ifa.gnt_ack = 1'b1;
        tick(); chk_a("burst_ack1", 8'b0010_0000, 3'd5, 1'b1);
        tick(); chk_a("burst_ack2", 8'b0010_0000, 3'd5, 1'b1);
        tick(); chk_a("burst_ack3", 8'b0010_0000, 3'd5, 1'b1);
        tick(); chk_a("burst_rel",  8'd0,         3'd5, 1'b0);
        ifa.gnt_ack = 1'b0;
        tick(); chk_a("regrant",    8'b0010_0000, 3'd5, 1'b1);

        // early empty with a simultaneous ack
        ifa.req = 8'd0;
        tick(); chk_a("drop_req", 8'd0, 3'd5, 1'b0);
        ifa.req = 8'b0000_1000;
        tick(); chk_a("grant3", 8'b0000_1000, 3'd3, 1'b1);
        ifa.gnt_ack = 1'b1;
        tick(); chk_a("early_ack1", 8'b0000_1000, 3'd3, 1'b1);
        tick(); chk_a("early_ack2", 8'b0000_1000, 3'd3, 1'b1);
        ifa.req = 8'd0;
        tick(); chk_a("early_empty", 8'd0, 3'd3, 1'b0);
        ifa.gnt_ack = 1'b0;
        tick(); chk_a("stay_idle", 8'd0, 3'd3, 1'b0);

        // asynchronous reset in the middle of a burst
        ifa.req = 8'b0010_0100;
        tick(); chk_a("pre_rst", 8'b0010_0000, 3'd5, 1'b1);
        #3 rst_n = 1'b0;
        #1 chk_a("async_rst", 8'd0, 3'd0, 1'b0);
        #2 rst_n = 1'b1;
        tick(); chk_a("rst_pri_zero", 8'b0000_0100, 3'd2, 1'b1);

        // ties and zero priority
        ifa.req = 8'd0;
        tick(); chk_a("rel_before_tie", 8'd0, 3'd2, 1'b0);
        ifa.req = 8'b1100_0010;
        tick(); chk_a("tie_zero", 8'b0000_0010, 3'd1, 1'b1);
        ifa.req = 8'd0;
        tick(); chk_a("rel_tie_zero", 8'd0, 3'd1, 1'b0);
        cfg_a(3'd1, 8'h20);
        cfg_a(3'd6, 8'h20);
        ifa.req = 8'b0100_0010;
        tick(); chk_a("tie_pri", 8'b0000_0010, 3'd1, 1'b1);
        cfg_a(3'd6, 8'hFF);
        chk_a("busy_cfg_hold", 8'b0000_0010, 3'd1, 1'b1);
        ifa.req = 8'd0;
        tick(); chk_a("rel_tie_pri", 8'd0, 3'd1, 1'b0);
        ifa.req = 8'b0100_0010;
        tick(); chk_a("cfg_applied", 8'b0100_0000, 3'd6, 1'b1);
        ifa.req = 8'd0;
        tick();

        // single-word bursts
        ifb.req = 8'b0000_0001;
        tick(); chk_b("b1_grant", 8'b0000_0001, 3'd0, 1'b1);
        ifb.gnt_ack = 1'b1;
        tick(); chk_b("b1_rel", 8'd0, 3'd0, 1'b0);
        ifb.gnt_ack = 1'b0;
        ifb.req     = 8'd0;

        // aging: ch0 boosted after three lost arbitrations
        cfg_b(3'd7, 8'hFF);
        cfg_b(3'd0, 8'h00);
        ifb.req     = 8'b1000_0001;
        ifb.gnt_ack = 1'b1;
        for (int k = 0; k < 6; k++) begin
            oh = 8'b1 << age_seq[k];
            tick(); chk_b($sformatf("age_grant%0d", k), oh, age_seq[k], 1'b1);
            tick(); chk_b($sformatf("age_rel%0d", k), 8'd0, age_seq[k], 1'b0);
        end
        ifb.gnt_ack = 1'b0;
        ifb.req     = 8'd0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
